// File: rtl/dmem_ctrl_pkg.sv
// Shared types and width helpers for the data-memory access controller.
// Holds FSM/owner enums and the counter width function.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_e;

  // $clog2 with a floor of one bit so degenerate
  // parameters still yield a legal vector.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// CPU/debug arbiter with bounded debug starvation.
// Ports: clk_i, rst_n_i, cpu_req_i, dbg_req_i, grant_i (IDLE grant), dbg_win_o.
module dmem_arb_pick
  import dmem_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic grant_i,
  output logic dbg_win_o
);

  localparam int SW = cw(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (STARVE_MAX != 0) &&
                   (starve_cnt == SMAX);

  assign dbg_win_o = dbg_req_i &
                     (~cpu_req_i | starved);

  // Counts CPU grants taken while debug waited;
  // saturates so debug wins once it hits the cap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      if (dbg_win_o) begin
        starve_cnt <= '0;
      end else if (dbg_req_i &&
                   starve_cnt != SMAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Fixed-latency Data_Memory sequencer shared by CPU MEM stage and debug port.
// Ports: cpu_*/dbg_* requesters, mem_* memory pins, busy_o; DMEM_ALIGN_CHECK_EN adds *_err_o.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_done_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          dbg_done_o,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic          cpu_err_o,
  output logic          dbg_err_o,
`endif
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int CW = cw(MEM_LAT);

  state_e        state, state_n;
  owner_e        owner;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [CW-1:0] cnt;

  logic          any_req, grant, dbg_win;
  logic          in_acc, last, done;
  logic          sel_we, bad;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign any_req = cpu_req_i | dbg_req_i;
  assign grant   = (state == IDLE) & any_req;

  dmem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .cpu_req_i(cpu_req_i),
    .dbg_req_i(dbg_req_i),
    .grant_i  (grant),
    .dbg_win_o(dbg_win)
  );

  assign sel_we    = dbg_win ? dbg_we_i : cpu_we_i;
  assign sel_addr  = dbg_win ? dbg_addr_i : cpu_addr_i;
  assign sel_wdata = dbg_win ? dbg_wdata_i : cpu_wdata_i;

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  assign bad = sel_addr[1:0] != 2'b00;
`else
  assign bad = 1'b0;
`endif

  assign in_acc = state == ACCESS;
  assign last   = in_acc && (cnt == '0);
  assign done   = state == DONE;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (any_req)
          state_n = bad ? DONE : ACCESS;
      ACCESS:
        if (last)
          state_n = DONE;
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      owner   <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (grant) begin
        owner   <= dbg_win ? OWN_DBG : OWN_CPU;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        rdata_q <= '0;
        cnt     <= CW'(MEM_LAT - 1);
`ifdef DMEM_ALIGN_CHECK_EN
        err_q   <= bad;
`endif
      end else if (in_acc) begin
        if (last)
          rdata_q <= mem_rdata_i;
        else
          cnt <= cnt - 1'b1;
      end
    end
  end

  // Pins idle at zero outside ACCESS; the write
  // strobe fires only on the final access cycle.
  assign mem_addr_o  = in_acc ? addr_q : '0;
  assign mem_wdata_o = in_acc ? wdata_q : '0;
  assign mem_we_o    = last & we_q;

  assign cpu_done_o  = done & (owner == OWN_CPU);
  assign dbg_done_o  = done & (owner == OWN_DBG);
  assign cpu_rdata_o = cpu_done_o ? rdata_q : '0;
  assign dbg_rdata_o = dbg_done_o ? rdata_q : '0;

`ifdef DMEM_ALIGN_CHECK_EN
  assign cpu_err_o = cpu_done_o & err_q;
  assign dbg_err_o = dbg_done_o & err_q;
`endif

  // Gated by reset so every output reads 0 while
  // the controller is held in reset.
  assign cpu_stall_o = rst_n_i & cpu_req_i &
                       ~cpu_done_o;
  assign busy_o      = state != IDLE;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl (MEM_LAT=2, STARVE_MAX=2).
// Stimulus queues expected responses; a negedge monitor checks them.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_done;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        cpu_err, dbg_err;
`endif
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;

  dmem_access_ctrl #(
    .AW(32), .DW(32),
    .MEM_LAT(2), .STARVE_MAX(2)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata),
    .cpu_done_o (cpu_done),
    .cpu_stall_o(cpu_stall),
    .dbg_req_i  (dbg_req),
    .dbg_we_i   (dbg_we),
    .dbg_addr_i (dbg_addr),
    .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata),
    .dbg_done_o (dbg_done),
`ifdef DMEM_ALIGN_CHECK_EN
    .cpu_err_o  (cpu_err),
    .dbg_err_o  (dbg_err),
`endif
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:63] = '{
    4: 32'hDEADBEEF, default: 32'h0};
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk)
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    bit          dbg;
    bit          chk_rd;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } wr_t;

  localparam int P_STALL = 0;
  localparam int P_BUSY  = 1;
  localparam int P_ADDR  = 2;
  localparam int P_WE    = 3;
  localparam int P_DONE  = 4;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } probe_t;

  rsp_t   rsp_q[$];
  wr_t    wr_q[$];
  probe_t pr_q[$];

  int checks = 0;
  int errors = 0;
  bit eot = 0;
  bit mon_done = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h want %h",
               name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] pval(input int s);
    case (s)
      P_STALL: return {31'b0, cpu_stall};
      P_BUSY:  return {31'b0, busy};
      P_ADDR:  return mem_addr;
      P_WE:    return {31'b0, mem_we};
      default: return {31'b0, cpu_done | dbg_done};
    endcase
  endfunction

  // Monitor: sole owner of the check counters.
  always @(negedge clk) begin
    rsp_t   r;
    wr_t    w;
    probe_t p;
    if (cpu_done || dbg_done) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        r = rsp_q.pop_front();
        chk("done_owner", {31'b0, dbg_done},
            {31'b0, r.dbg});
        chk("done_cycle", cyc, r.cyc);
        chk("both_done", {31'b0, cpu_done & dbg_done}, 0);
        if (r.chk_rd)
          chk("rdata",
              r.dbg ? dbg_rdata : cpu_rdata, r.rdata);
        chk("other_rdata",
            r.dbg ? cpu_rdata : dbg_rdata, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("err", {31'b0, cpu_err | dbg_err},
            {31'b0, r.err});
`endif
      end
    end
`ifdef DMEM_ALIGN_CHECK_EN
    if ((cpu_err && !cpu_done) || (dbg_err && !dbg_done))
      chk("stray_err", 1, 0);
`endif
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_we", 1, 0);
      end else begin
        w = wr_q.pop_front();
        chk("we_cycle", cyc, w.cyc);
        chk("we_addr", mem_addr, w.addr);
        chk("we_wdata", mem_wdata, w.wdata);
      end
    end
    while (pr_q.size() != 0 && pr_q[0].cyc <= cyc) begin
      p = pr_q.pop_front();
      chk($sformatf("probe%0d_c%0d", p.sig, p.cyc),
          pval(p.sig), p.val);
    end
    if (eot && !mon_done) begin
      chk("rsp_left", rsp_q.size(), 0);
      chk("wr_left", wr_q.size(), 0);
      chk("probe_left", pr_q.size(), 0);
      mon_done = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rsp(input bit d, input bit c,
                         input logic [31:0] rd,
                         input bit e, input int at);
    rsp_t r;
    r = '{dbg: d, chk_rd: c, rdata: rd,
          err: e, cyc: at};
    rsp_q.push_back(r);
  endtask

  task automatic exp_wr(input logic [31:0] a,
                        input logic [31:0] d,
                        input int at);
    wr_t w;
    w = '{addr: a, wdata: d, cyc: at};
    wr_q.push_back(w);
  endtask

  task automatic probe(input int at, input int s,
                       input logic [31:0] v);
    probe_t p;
    p = '{cyc: at, sig: s, val: v};
    pr_q.push_back(p);
  endtask

  task automatic wait_done(input bit is_dbg);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_dbg ? dbg_done : cpu_done) return;
    end
  endtask

  task automatic cpu_run(input bit we,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input int n);
    cpu_we = we; cpu_addr = a; cpu_wdata = d;
    cpu_req = 1;
    for (int k = 0; k < n; k++) wait_done(0);
    tick();
    cpu_req = 0;
  endtask

  task automatic dbg_run(input bit we,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input int n);
    dbg_we = we; dbg_addr = a; dbg_wdata = d;
    dbg_req = 1;
    for (int k = 0; k < n; k++) wait_done(1);
    tick();
    dbg_req = 0;
  endtask

  int t;

  initial begin
    rst_n = 0;
    cpu_req = 0; cpu_we = 0;
    cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0;
    dbg_addr = 0; dbg_wdata = 0;

    // reset state
    for (int c = 1; c <= 2; c++) begin
      probe(c, P_BUSY, 0);
      probe(c, P_ADDR, 0);
      probe(c, P_WE, 0);
      probe(c, P_DONE, 0);
    end
    tick(); tick(); tick();
    rst_n = 1;

    // 1: cpu read, done at t+3, stall t..t+2
    tick(); t = cyc;
    exp_rsp(0, 1, 32'hDEADBEEF, 0, t + 3);
    probe(t, P_STALL, 1);
    probe(t + 1, P_STALL, 1);
    probe(t + 1, P_ADDR, 32'h10);
    probe(t + 2, P_STALL, 1);
    probe(t + 3, P_STALL, 0);
    cpu_run(0, 32'h10, 0, 1);

    // 2: dbg write, single strobe at t+2
    tick(); t = cyc;
    exp_wr(32'h20, 32'h12345678, t + 2);
    exp_rsp(1, 0, 0, 0, t + 3);
    probe(t + 1, P_BUSY, 1);
    probe(t + 1, P_WE, 0);
    probe(t + 3, P_WE, 0);
    dbg_run(1, 32'h20, 32'h12345678, 1);

    // 3: simultaneous requests, CPU first
    tick(); t = cyc;
    exp_rsp(0, 1, 32'hDEADBEEF, 0, t + 3);
    exp_rsp(1, 1, 32'h12345678, 0, t + 7);
    fork
      cpu_run(0, 32'h10, 0, 1);
      dbg_run(0, 32'h20, 0, 1);
    join

    // 4: starvation cap 2 -> cpu,cpu,dbg,cpu,cpu,dbg
    tick(); t = cyc;
    exp_rsp(0, 1, 32'hDEADBEEF, 0, t + 3);
    exp_rsp(0, 1, 32'hDEADBEEF, 0, t + 7);
    exp_rsp(1, 1, 32'h12345678, 0, t + 11);
    exp_rsp(0, 1, 32'hDEADBEEF, 0, t + 15);
    exp_rsp(0, 1, 32'hDEADBEEF, 0, t + 19);
    exp_rsp(1, 1, 32'h12345678, 0, t + 23);
    fork
      cpu_run(0, 32'h10, 0, 4);
      dbg_run(0, 32'h20, 0, 2);
    join

    // 5: reset during a write access
    tick(); t = cyc;
    cpu_we = 1; cpu_addr = 32'h30;
    cpu_wdata = 32'hCAFEF00D; cpu_req = 1;
    probe(t + 1, P_BUSY, 0);
    probe(t + 1, P_ADDR, 0);
    probe(t + 1, P_WE, 0);
    probe(t + 1, P_DONE, 0);
    probe(t + 2, P_WE, 0);
    probe(t + 3, P_DONE, 0);
    probe(t + 3, P_BUSY, 0);
    probe(t + 4, P_BUSY, 0);
    tick();
    rst_n = 0; cpu_req = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    tick(); t = cyc;
    exp_rsp(0, 1, 32'h0, 0, t + 3);
    cpu_run(0, 32'h30, 0, 1);

`ifdef DMEM_ALIGN_CHECK_EN
    // 6: misaligned write completes at t+1 with error
    tick(); t = cyc;
    exp_rsp(0, 1, 32'h0, 1, t + 1);
    probe(t, P_WE, 0);
    probe(t + 1, P_WE, 0);
    probe(t + 2, P_WE, 0);
    cpu_run(1, 32'h13, 32'hA5A5A5A5, 1);
`endif

    tick(); tick(); tick();
    eot = 1;
    for (int i = 0; i < 10 && !mon_done; i++)
      @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
